// File: rtl/uart_rx_baud.sv
// 16x oversampling 8N1 UART receiver with integrated baud tick generator.
// Ports: clk, reset (sync, active-high), rx in; tick, rx_done_tick, dout out.
// Optional glitch rejection of short start bits: define UART_RX_START_CHECK_EN.
module uart_rx_baud #(
  parameter int N_BITS  = 8,
  parameter int N_COUNT = 163,
  parameter int SB_TICK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              tick,
  output logic              rx_done_tick,
  output logic [N_BITS-1:0] dout
);

  localparam int CW = $clog2(N_COUNT);
  localparam int NW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [CW-1:0] C_LAST  = CW'(N_COUNT - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(N_BITS - 1);
  localparam logic [3:0]    SB_LAST = 4'(SB_TICK - 1);
  localparam logic [3:0]    S_MID   = 4'd7;
  localparam logic [3:0]    S_END   = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset)     count_q <= '0;
    else if (tick) count_q <= '0;
    else           count_q <= count_q + 1'b1;
  end

  assign tick = (count_q == C_LAST);

  state_t            state_q, state_d;
  logic [3:0]        s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [N_BITS-1:0] b_q, b_d;
  logic [N_BITS-1:0] dout_q, dout_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
`ifdef UART_RX_START_CHECK_EN
            // Line back high at mid start bit: noise, not a frame.
            if (rx) begin
              state_d = IDLE;
              s_d     = '0;
            end else begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end
`else
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
`endif
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_END) begin
            s_d = '0;
            b_d = {rx, b_q[N_BITS-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == SB_LAST) begin
            state_d = IDLE;
            dout_d  = b_q;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;

endmodule

// File: tb/tb_uart_rx_baud.sv
// Testbench for uart_rx_baud: tick timing, frames, glitch, reset, framing.
// Uses a short N_COUNT so whole frames fit a small cycle budget.
module tb_uart_rx_baud;

  localparam int NC  = 5;
  localparam int BIT = 16 * NC;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       tick;
  logic       rx_done_tick;
  logic [7:0] dout;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic       prev_done = 1'b0;

  uart_rx_baud #(
    .N_BITS (8),
    .N_COUNT(NC),
    .SB_TICK(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .tick        (tick),
    .rx_done_tick(rx_done_tick),
    .dout        (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_done;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each done pulse pops the next expected byte.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      check("done_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0)
        check("unexpected_done", {31'd0, rx_done_tick}, 32'd0);
      else
        check("dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
    end
    prev_done = rx_done_tick;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_cyc(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    wait_cyc(1);
    check("rst_done", {31'd0, rx_done_tick}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] glitch_dout;
    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_done: 1'b1, exp_dout: 8'h55};
    vecs[1] = '{data: 8'hA3, stop: 1'b1, exp_done: 1'b1, exp_dout: 8'hA3};
    vecs[2] = '{data: 8'h0F, stop: 1'b1, exp_done: 1'b1, exp_dout: 8'h0F};

    reset = 1'b1;
    rx    = 1'b1;
    wait_cyc(2);
    pulse_reset();

    // Tick at cycles NC-1, 2NC-1, ... after release.
    for (int k = 0; k < 3 * NC; k++) begin
      check($sformatf("tick_k%0d", k), {31'd0, tick},
            {31'd0, (k % NC) == NC - 1});
      wait_cyc(1);
    end
    check("idle_dout", {24'd0, dout}, 32'd0);

    // Back-to-back frames straight from the table.
    for (int i = 0; i < 3; i++) begin
      if (vecs[i].exp_done) exp_q.push_back(vecs[i].exp_dout);
      send_frame(vecs[i].data, vecs[i].stop);
    end
    wait_cyc(2 * BIT);
    check("hold_dout", {24'd0, dout}, 32'h0F);

    // Short low glitch on an idle line.
`ifdef UART_RX_START_CHECK_EN
    glitch_dout = 8'h0F;
`else
    glitch_dout = 8'hFF;
    exp_q.push_back(8'hFF);
`endif
    rx = 1'b0;
    wait_cyc(3 * NC);
    rx = 1'b1;
    wait_cyc(12 * BIT);
    check("glitch_dout", {24'd0, dout}, {24'd0, glitch_dout});

    // Reset in the middle of data bit 4 of 0x3C.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h3C >> i));
    rx = 1'b1;
    wait_cyc(BIT / 2);
    pulse_reset();
    wait_cyc(2 * BIT);
    check("post_rst_dout", {24'd0, dout}, 32'd0);

    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_cyc(BIT);
    check("rx_3c_dout", {24'd0, dout}, 32'h3C);

    // Low stop bit still completes the frame.
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0);
    check("stop0_dout", {24'd0, dout}, 32'h81);
    rx = 1'b1;
    pulse_reset();
    wait_cyc(BIT);

    check("pending", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
